// File: rtl/rs_outer_deinterleaver.sv
// rs_outer_deinterleaver: Forney convolutional byte deinterleaver (I=12, M=17)
// for the DVB-T outer code path, upstream of RS_Decoder.
// Optional feature macro: DEINT_SYNC_ALIGN_EN adds a HUNT/VERIFY/LOCK packet sync
// search that aligns the branch commutator to 0x47/0xB8 sync bytes.
// Handshake: a byte is taken on every rising edge where in_valid is high (no
// backpressure); out_valid marks msg_out for exactly one cycle per emitted byte.
module rs_outer_deinterleaver #(
  parameter int I = 12,
  parameter int M = 17
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  input  logic [7:0]           msg_in,
  output logic                 out_valid,
  output logic [7:0]           msg_out,
  output logic                 sync_lock,
  output logic [1:0]           o_dbg_state,
  output logic [$clog2(I)-1:0] o_dbg_br
);

  localparam int DEPTH = M * I * (I - 1) / 2;   // total delay-line bytes
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(M * (I - 1));
  localparam int BW    = $clog2(I);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  // Branch j delays by (I-1-j)*M uses; branch I-1 has no storage.
  function automatic int f_delay(input int j);
    return (I - 1 - j) * M;
  endfunction

  // Base address of branch j: sum of the delays of all lower branches.
  function automatic int f_base(input int j);
    return M * (j * (I - 1) - (j * (j - 1)) / 2);
  endfunction

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_ptr [I];
  logic [I-1:0]  r_filled;
  logic [BW-1:0] r_br;
  logic          r_out_valid;
  logic [7:0]    r_msg_out;

  logic          w_accept;
  logic          w_restart;
  logic          w_out_en;
  logic [BW-1:0] w_br;
  logic          w_pass;
  logic [PW-1:0] w_ptr;
  logic          w_filled;
  logic          w_last;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_rd;

  // A restart (sync found while hunting) treats this byte as branch 0 of a fresh array.
  assign w_br = w_restart ? '0 : r_br;

  // Address and fill status of the branch selected for the current byte.
  always_comb begin
    w_pass   = (w_br == BW'(I - 1));
    w_ptr    = w_restart ? '0 : r_ptr[w_br];
    w_filled = w_restart ? 1'b0 : r_filled[w_br];
    w_last   = (int'(w_ptr) == f_delay(int'(w_br)) - 1);
    w_addr   = w_pass ? '0 : AW'(f_base(int'(w_br)) + int'(w_ptr));
    w_rd     = r_mem[w_addr];
  end

  // Delay-line storage: the new byte replaces the one read out at the same address.
  always_ff @(posedge Clk) begin
    if (!Reset && w_accept && !w_pass) begin
      r_mem[w_addr] <= msg_in;
    end
  end

  // Commutator, per-branch pointers and fill flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_br <= '0;
      for (int j = 0; j < I; j++) r_ptr[j] <= '0;
      r_filled <= {1'b1, {(I-1){1'b0}}};
    end else if (w_accept) begin
      if (w_restart) begin
        for (int j = 0; j < I; j++) r_ptr[j] <= '0;
        r_filled <= {1'b1, {(I-1){1'b0}}};
      end
      if (!w_pass) begin
        r_ptr[w_br] <= w_last ? '0 : w_ptr + 1'b1;
        if (w_last) r_filled[w_br] <= 1'b1;
      end
      r_br <= w_pass ? '0 : w_br + 1'b1;
    end
  end

  // Registered output; unfilled branches emit 0x00 since memory is never cleared.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_msg_out   <= 8'h00;
    end else begin
      r_out_valid <= w_accept && w_out_en;
      if (w_accept) begin
        r_msg_out <= w_pass ? msg_in : (w_filled ? w_rd : 8'h00);
      end
    end
  end

`ifdef DEINT_SYNC_ALIGN_EN
  localparam int CW  = I * M;          // codeword length, sync spacing
  localparam int CNW = $clog2(CW);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CNW-1:0] r_cnt;
  logic [1:0]     r_hits;
  logic [1:0]     r_miss;
  logic           w_is_sync;
  logic           w_at_sync;

  // Sync search state register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_HUNT;
    else       r_state <= w_state_nxt;
  end

  // Next state and datapath gating for the sync search.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_restart   = 1'b0;
    w_out_en    = 1'b0;
    w_is_sync   = (msg_in == 8'h47) || (msg_in == 8'hB8);
    w_at_sync   = (r_cnt == '0);
    case (r_state)
      S_HUNT: begin
        if (in_valid && w_is_sync) begin
          w_accept    = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = S_VERIFY;
        end
      end
      S_VERIFY: begin
        w_accept = in_valid;
        if (in_valid && w_at_sync) begin
          if (!w_is_sync)          w_state_nxt = S_HUNT;
          else if (r_hits == 2'd2) w_state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        w_accept = in_valid;
        w_out_en = 1'b1;
        if (in_valid && w_at_sync && !w_is_sync && r_miss == 2'd3) w_state_nxt = S_HUNT;
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // Codeword position counter plus consecutive hit/miss counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_hits <= '0;
      r_miss <= '0;
    end else if (in_valid) begin
      case (r_state)
        S_HUNT: begin
          if (w_is_sync) begin
            r_cnt  <= CNW'(1);
            r_hits <= 2'd1;
            r_miss <= '0;
          end
        end
        S_VERIFY, S_LOCK: begin
          r_cnt <= (r_cnt == CNW'(CW - 1)) ? '0 : r_cnt + 1'b1;
          if (w_at_sync) begin
            if (w_is_sync) begin
              r_hits <= (r_hits == 2'd3) ? r_hits : r_hits + 1'b1;
              r_miss <= '0;
            end else begin
              r_miss <= r_miss + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sync_lock   = (r_state == S_LOCK);
  assign o_dbg_state = r_state;
`else
  // Without sync search every byte is accepted and the stream is assumed aligned.
  always_comb begin
    w_accept  = in_valid;
    w_restart = 1'b0;
    w_out_en  = 1'b1;
  end

  assign sync_lock   = 1'b1;
  assign o_dbg_state = S_LOCK;
`endif

  assign out_valid = r_out_valid;
  assign msg_out   = r_msg_out;
  assign o_dbg_br  = r_br;

endmodule

// File: tb/tb_rs_outer_deinterleaver.sv
// tb_rs_outer_deinterleaver: self-checking bench for rs_outer_deinterleaver.
// Reference model: accepted byte k on branch j=k%12 reappears (11-j)*204 accepted
// bytes later, and is 0x00 before that; a reference interleaver builds loopback streams.
module tb_rs_outer_deinterleaver;

  localparam int CWL = 204;
  localparam int LAT = 2244;
  localparam int NCW = 20;
`ifdef DEINT_SYNC_ALIGN_EN
  localparam logic SL_RST = 1'b0;
`else
  localparam logic SL_RST = 1'b1;
`endif

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] msg_in;
  logic       out_valid;
  logic [7:0] msg_out;
  logic       sync_lock;
  logic [1:0] dbg_state;
  logic [3:0] dbg_br;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] hist[$];
  logic [7:0] out_log[$];
  logic [7:0] loop_log[$];
  logic [7:0] orig[$];
  logic [7:0] tx[$];
  vec_t       tbl[48];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  rs_outer_deinterleaver dut (
    .Clk        (clk),
    .Reset      (reset),
    .in_valid   (in_valid),
    .msg_in     (msg_in),
    .out_valid  (out_valid),
    .msg_out    (msg_out),
    .sync_lock  (sync_lock),
    .o_dbg_state(dbg_state),
    .o_dbg_br   (dbg_br)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source codewords (0x47 then counter payload) and their reference interleaving.
  task automatic build_stream(input int ncw);
    int s;
    orig.delete();
    tx.delete();
    for (int i = 0; i < ncw * CWL; i++) orig.push_back((i % CWL == 0) ? 8'h47 : 8'(i));
    for (int k = 0; k < ncw * CWL; k++) begin
      s = k - (k % 12) * CWL;
      tx.push_back((s >= 0) ? orig[s] : 8'h00);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic step(input logic rst, input logic v, input logic [7:0] b);
    logic       exp_v;
    logic [7:0] e;
    int         k;
    int         d;
    reset    = rst;
    in_valid = v;
    msg_in   = b;
    exp_v    = 1'b0;
    if (rst) begin
      hist.delete();
      exp_q.delete();
    end else if (v) begin
      hist.push_back(b);
      k = hist.size() - 1;
      d = (11 - (k % 12)) * CWL;
      exp_q.push_back((k >= d) ? hist[k - d] : 8'h00);
      exp_v = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, exp_v);
    if (rst) begin
      check("rst_msg_out", msg_out, 32'h0);
      check("rst_br", dbg_br, 32'h0);
      check("rst_sync_lock", sync_lock, SL_RST);
    end
    if (exp_v) begin
      e = exp_q.pop_front();
      check("msg_out", msg_out, e);
    end
    if (out_valid) out_log.push_back(msg_out);
  endtask

`ifndef DEINT_SYNC_ALIGN_EN
  task automatic compare_logs(input string name);
    int n;
    check({name, "_len"}, out_log.size(), loop_log.size());
    n = (out_log.size() < loop_log.size()) ? out_log.size() : loop_log.size();
    for (int i = 0; i < n; i++) check(name, out_log[i], loop_log[i]);
  endtask

  // Branch 11 pass-through and fill masking, table driven with gaps.
  task automatic table_test();
    int acc = 0;
    for (int i = 0; i < 48; i++) begin
      tbl[i].v = (i % 5 != 4);
      if (tbl[i].v) begin
        tbl[i].d  = (acc % 12 == 11) ? 8'hA5 : 8'(i * 7 + 3);
        tbl[i].ev = 1'b1;
        tbl[i].ed = (acc % 12 == 11) ? 8'hA5 : 8'h00;
        acc++;
      end else begin
        tbl[i].d  = 8'h5A;
        tbl[i].ev = 1'b0;
        tbl[i].ed = 8'h00;
      end
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h47);
    for (int i = 0; i < 48; i++) begin
      step(1'b0, tbl[i].v, tbl[i].d);
      check("tbl_valid", out_valid, tbl[i].ev);
      if (tbl[i].ev) check("tbl_data", msg_out, tbl[i].ed);
    end
  endtask

  task automatic loopback_test();
    step(1'b1, 1'b1, 8'h00);
    out_log.delete();
    for (int i = 0; i < tx.size(); i++) step(1'b0, 1'b1, tx[i]);
    check("loop_len", out_log.size(), tx.size());
    for (int i = LAT; i < out_log.size(); i++) check("loop_data", out_log[i], orig[i - LAT]);
    loop_log = out_log;
  endtask

  task automatic gapped_test();
    int idx = 0;
    step(1'b1, 1'b1, 8'h00);
    out_log.delete();
    while (idx < tx.size()) begin
      if ($urandom_range(0, 99) < 30) begin
        step(1'b0, 1'b0, 8'($urandom));
      end else begin
        step(1'b0, 1'b1, tx[idx]);
        idx++;
      end
    end
    compare_logs("gap_data");
  endtask

  task automatic midreset_test();
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, tx[i]);
    step(1'b1, 1'b1, tx[1000]);
    out_log.delete();
    for (int i = 0; i < tx.size(); i++) step(1'b0, 1'b1, tx[i]);
    compare_logs("midrst_data");
  endtask

  task automatic random_test();
    step(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, ($urandom_range(0, 99) < 75), 8'($urandom));
    end
  endtask
`else
  task automatic drive(input logic [7:0] b);
    reset    = 1'b0;
    in_valid = 1'b1;
    msg_in   = b;
    @(posedge clk);
    #1;
  endtask

  // Junk prefix, alignment, lock, steady output, then loss of lock.
  task automatic sync_test();
    logic [7:0] b;
    build_stream(25);
    step(1'b1, 1'b1, 8'h47);
    for (int i = 0; i < 37; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h47 || b == 8'hB8);
      drive(b);
    end
    check("hunt_lock", sync_lock, 32'h0);
    check("hunt_state", dbg_state, 32'h0);
    for (int k = 0; k <= 24 * CWL; k++) begin
      b = tx[k];
      if (k >= 21 * CWL && k % CWL == 0) b = 8'h00;
      drive(b);
      check("sync_valid", out_valid, (k >= 2 * CWL + 1));
      if (k == 0)       check("verify_state", dbg_state, 32'h1);
      if (k == 2 * CWL - 1) check("prelock", sync_lock, 32'h0);
      if (k == 2 * CWL) begin
        check("lock", sync_lock, 32'h1);
        check("lock_state", dbg_state, 32'h2);
      end
      if (k >= LAT && k < 21 * CWL) check("sync_data", msg_out, orig[k - LAT]);
      if (k == 23 * CWL) check("lock_after_3_miss", sync_lock, 32'h1);
      if (k == 24 * CWL) begin
        check("unlock", sync_lock, 32'h0);
        check("unlock_state", dbg_state, 32'h0);
      end
    end
  endtask
`endif

  // ---------------- main sequence + report ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    msg_in   = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'($urandom));
`ifdef DEINT_SYNC_ALIGN_EN
    sync_test();
`else
    build_stream(NCW);
    table_test();
    loopback_test();
    gapped_test();
    midreset_test();
    random_test();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs_outer_deinterleaver.md
# rs_outer_deinterleaver

Forney convolutional byte deinterleaver (I = 12 branches, M = 17) for the DVB-T outer code path. It sits directly upstream of `RS_Decoder` and takes bytes from the inner (Viterbi) decoder. It undoes the transmitter's outer interleaving so that `RS_Decoder` receives contiguous 204-byte RS(204,188) codewords on its `msg_in`. Byte-serial, one byte per accepted strobe, with a registered output.

## Interface
- `I`, 12: number of branches.
- `M`, 17: delay unit per branch, in bytes. I×M = 204.
- `Clk`  in  1: system clock; everything is on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `msg_in` carries a valid byte this cycle.
- `msg_in`  in  8: interleaved byte from the inner decoder.
- `out_valid`  out  1: `msg_out` is valid. Drives the `RS_Decoder` input strobe.
- `msg_out`  out  8: deinterleaved byte; connects to `RS_Decoder.msg_in`.
- `sync_lock`  out  1: branch commutator is aligned to the packet sync (see Configuration).

## Operation
- **Branch counter `br`** (0..I-1):
  - Selects the branch for the current accepted byte.
  - Increments on each `in_valid`; wraps 11→0.
- **Branch delays:**
  - Branch j delays its bytes by D(j) = (I-1-j)×M branch uses: branch 0 = 187, branch 11 = 0.
  - Total storage is 1122 bytes in a single memory. Branch j occupies base address B(j) = M×Σ_{k<j}(I-1-k).
- **Per-branch pointer `ptr[j]`** (0..D(j)-1): on an accepted byte for branch j with D(j) > 0:
  - read `mem[B(j)+ptr[j]]` as the output;
  - write `msg_in` to the same address;
  - `ptr[j]` ← `ptr[j]`+1, wrapping at D(j)-1 → 0.
  - Branch 11 passes `msg_in` straight through (registered).
- **Fill flags `filled[j]`:**
  - Set when `ptr[j]` first wraps.
  - While `filled[j]` = 0, the output byte for branch j is forced to 0x00. Memory contents are never reset.
  - Branch 11 is filled from reset.
- **Reset clears:** `br`, all `ptr[j]`, all `filled[j]`, `out_valid`, `msg_out` (0x00), and `sync_lock` (0 with the macro, 1 without).
- **`in_valid` low:** no state changes and `out_valid` = 0 next cycle. Gaps of any length are allowed.
- **Reset asserted mid-stream:** takes priority over `in_valid` in the same cycle. The byte presented in that cycle is discarded.

## Timing
- `msg_out`/`out_valid` are registered. The output for an input accepted in cycle n appears in cycle n+1.
- End-to-end, a byte entering branch j re-emerges (I-1-j)×M×I = (11-j)×204 accepted bytes later.
  - Combined with the transmit interleaver, the total is a constant 2244 bytes (11 codewords).
- Throughput is one byte per cycle, sustained. The memory read and write to the same address in the same cycle return the old data (read-before-write).
- The first valid codeword reaches `RS_Decoder` after 2244 accepted bytes from alignment.

## Configuration
- **`DEINT_SYNC_ALIGN_EN` defined:** sync search state machine with states HUNT, VERIFY, LOCK.
  - **HUNT:**
    - A byte equal to 0x47 or 0xB8 forces `br` := 0 for that byte and clears all `ptr`/`filled`.
    - The state moves to VERIFY and a 204-byte counter starts.
  - **VERIFY:**
    - Each byte at counter = 0 must be 0x47 or 0xB8.
    - Three consecutive hits → LOCK with `sync_lock` = 1.
    - A miss → HUNT.
  - **LOCK:**
    - Four consecutive misses → HUNT, and `sync_lock` falls on the cycle after the fourth miss.
    - Hits reset the miss count.
  - While not in LOCK, `out_valid` is held at 0.
- **Macro undefined:**
  - No sync logic.
  - `br` starts at 0 after reset; upstream guarantees that the first byte after reset is a sync byte.
  - `sync_lock` is held at 1 after reset.

## Test plan
- **Reset values:** assert `Reset` for 3 cycles with `in_valid` = 1 → `out_valid` = 0, `msg_out` = 0x00, `br` = 0 throughout, and `sync_lock` = 0 (macro) or 1 (no macro).
- **Loopback:** feed a reference interleaver output of 20 codewords (each starts 0x47, payload = counter) continuously → from accepted byte 2244 onward, `msg_out` equals the original stream exactly, in 204-byte codewords beginning with 0x47.
- **Branch 11 and fill masking:** input bytes 11, 23, 35 (branch 11) = 0xA5 → `msg_out` = 0xA5 one cycle later. Branch 0 outputs during the first 2244 bytes → 0x00.
- **Gapped input:** same stream as the loopback test with `in_valid` deasserted on a random 30% of cycles → identical output byte sequence and no `out_valid` pulse during gaps.
- **Mid-stream reset:** pulse `Reset` at byte 1000, then restart the stream → output matches a fresh run, and the byte present on the reset cycle is dropped.
- **Sync alignment (macro on):**
  - Prepend 37 junk bytes (no 0x47/0xB8) to the loopback stream → HUNT, then VERIFY, then LOCK after the third sync. `sync_lock` = 1, and output is correct after lock + 2244 bytes.
  - Corrupt 4 consecutive sync bytes → `sync_lock` drops and the block returns to HUNT.
